song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Plays a song stored in the 256x32 song ROM (`ram32x4`, read-only) through `Audio_Controller`.
- Steps through ROM words, decodes each into a tone half-period and a duration, and generates a square-wave sample stream.
- Pushes samples into the controller's output FIFO using the `audio_out_allowed` / `write_audio_out` handshake.
- Sits between the top level, the song ROM and `Audio_Controller`, replacing the constant-sample hookup.

Parameters:
- TICK_CYCLES, 50000, `CLOCK_50` cycles per duration tick (1 ms at 50 MHz).
- AMPLITUDE, 32'd10000000, sample magnitude; positive phase is +AMPLITUDE, negative phase is its two's complement.
- RD_LAT, 2, cycles from a `mem_address` change until `mem_q` is valid.

Ports:
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins playback at `song_base`.
- `stop`  in  1  one-cycle pulse; aborts playback.
- `song_base`  in  8  first ROM address of the song; sampled on `start`.
- `mem_address`  out  8  song ROM address (registered).
- `mem_q`  in  32  song ROM read data.
- `audio_out_allowed`  in  1  controller output FIFO has space.
- `write_audio_out`  out  1  sample write strobe.
- `left_channel_audio_out`  out  32  sample, left channel.
- `right_channel_audio_out`  out  32  sample, right channel (always equal to left).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the song ends normally.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, ports `CLOCK_50` / `reset`.
- Reset values: all outputs 0, `mem_address` 0, state IDLE.
- ROM word format:
  - bit 31: END flag.
  - [30:20]: duration in ticks (11 bits unsigned).
  - [19:0]: half-period in `CLOCK_50` cycles (20 bits unsigned).
  - half-period 0 means a rest: sample 0 for the whole duration.
- IDLE:
  - On `start`: `mem_address` <= `song_base`, latch `song_base`, go to FETCH.
  - Otherwise hold.
- FETCH:
  - Wait exactly RD_LAT cycles, then go to DECODE.
- DECODE (one cycle):
  - END=1: go to FINISH.
  - Duration 0: address+1, go to FETCH; no samples are produced for this word.
  - Otherwise: load duration and half-period, clear tick and phase counters, set polarity positive, go to PLAY.
- PLAY:
  - Tick counter counts 0..TICK_CYCLES-1; on wrap, the remaining-duration count decrements.
  - When the remaining duration reaches 0: address+1, go to FETCH.
  - Phase counter counts 0..half_period-1 and toggles polarity on wrap.
  - Sample = +AMPLITUDE / -AMPLITUDE by polarity, or 0 for a rest.
- FINISH:
  - Pulse `done` for one cycle, go to IDLE.
- Write handshake:
  - Only in PLAY, `write_audio_out` is registered high for one cycle when `audio_out_allowed`=1 and `write_audio_out` was low in the previous cycle.
  - This guarantees at least one low cycle between strobes, so writes never overflow the FIFO.
  - Sample outputs are valid whenever `write_audio_out`=1.
- Address wrap:
  - `mem_address` increments modulo 256.
  - If it increments back to the latched base without an END word, go to FINISH (256-word cap).
- `stop` in any non-IDLE state:
  - Next cycle: state IDLE, `write_audio_out`=0, samples 0, `done` not pulsed.
- Simultaneous events:
  - `start` and `stop` in the same cycle: `stop` wins.
  - `start` while busy: ignored.
- `reset` mid-playback: returns to the reset values in the next cycle, regardless of handshake state.

Optional Feature:
- Macro: SONG_LOOP_EN.
- Defined: FINISH pulses `done`, then returns to FETCH at the latched base; playback repeats until `stop` or `reset`.
- Not defined: FINISH returns to IDLE as described above.

Decomposition:
- Package `song_pkg`:
  - word field positions and widths (END bit, DUR_MSB/LSB, HP_MSB/LSB);
  - state encoding (IDLE, FETCH, DECODE, PLAY, FINISH);
  - the default AMPLITUDE.
- One sub-module, `tone_gen`: half-period counter plus polarity flip-flop.
  - Inputs: `load`, `half_period`, `enable`.
  - Output: signed sample.
- The FSM, tick counter and handshake stay in `song_sequencer`.

Test Plan (TICK_CYCLES=10 for simulation; ROM model with 2-cycle latency):
- ROM[0]={0,11'd3,20'd4}, ROM[1]=END; `start` with base 0 -> exactly 30 PLAY cycles; sample toggles every 4 cycles starting at +10000000; `done` pulses once; `busy` drops.
- `audio_out_allowed` held 0 for 20 cycles mid-note -> no `write_audio_out` during that window; strobes resume with no back-to-back highs.
- ROM[5]={0,11'd0,20'd7}, ROM[6]={0,11'd2,20'd0}, ROM[7]=END; `start` with base 5 -> word 5 skipped; 20 cycles of sample 0 (rest); then `done`.
- `stop` 8 cycles into a note -> next cycle IDLE, `write_audio_out`=0, no `done` pulse; a later `start` replays from base.
- ROM filled with 256 non-END words of duration 1; `start` with base 200 -> address wraps 255->0, FINISH reached when the address returns to 200; with SONG_LOOP_EN, playback restarts at 200.
- `reset` asserted during PLAY with `write_audio_out` high -> all outputs 0 the next cycle; `start` and `stop` in the same cycle from IDLE -> stays IDLE.

Source files
------------

// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: ROM word fields, FSM states, default amplitude.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package song_pkg;

   // ROM word layout: {END, duration[10:0], half_period[19:0]}
   localparam int END_BIT = 31;
   localparam int DUR_MSB = 30;
   localparam int DUR_LSB = 20;
   localparam int HP_MSB  = 19;
   localparam int HP_LSB  = 0;
   localparam int DUR_W   = DUR_MSB - DUR_LSB + 1;
   localparam int HP_W    = HP_MSB - HP_LSB + 1;

   localparam logic [31:0] AMPLITUDE_DEF = 32'd10000000;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      PLAY,
      FINISH
   } state_t;

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: half-period counter plus polarity flip-flop.
// Latency: sample is combinational from internal registers; load takes effect next cycle.
// Backpressure: none; advances one phase step per enabled cycle.
// Ports: clk, reset (sync, active-high), load (latch half_period, restart at +),
//        enable (advance phase), half_period (0 = rest), sample (signed output).
module tone_gen
   import song_pkg::*;
#(
   parameter logic [31:0] AMPLITUDE = AMPLITUDE_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                enable,
   input  logic [HP_W-1:0]     half_period,
   output logic signed [31:0]  sample
);

   logic [HP_W-1:0] hp_q;
   logic [HP_W-1:0] phase;
   logic            pol;

   always_ff @(posedge clk) begin
      if (reset) begin
         hp_q  <= '0;
         phase <= '0;
         pol   <= 1'b0;
      end else if (load) begin
         hp_q  <= half_period;
         phase <= '0;
         pol   <= 1'b1;
      end else if (enable && (hp_q != '0)) begin
         // polarity flips after exactly hp_q enabled cycles
         if (phase == hp_q - 1'b1) begin
            phase <= '0;
            pol   <= ~pol;
         end else begin
            phase <= phase + 1'b1;
         end
      end
   end

   always_comb begin
      if (hp_q == '0)
         sample = '0;
      else if (pol)
         sample = $signed(AMPLITUDE);
      else
         sample = -$signed(AMPLITUDE);
   end

endmodule

// File: rtl/song_sequencer.sv
// Song player: walks ROM words, decodes tone/duration, streams square-wave samples to the audio FIFO.
// Latency: RD_LAT fetch cycles + 1 decode cycle per word; samples registered one cycle after PLAY.
// Backpressure: write strobe only when audio_out_allowed, never on consecutive cycles; notes keep time regardless.
// Ports: CLOCK_50, reset (sync, active-high), start/stop pulses, song_base, mem_address/mem_q (song ROM),
//        audio_out_allowed/write_audio_out, left/right_channel_audio_out, busy, done.
// Build option: define SONG_LOOP_EN to restart the song at its base after each end instead of idling.
module song_sequencer
   import song_pkg::*;
#(
   parameter int          TICK_CYCLES = 50000,
   parameter logic [31:0] AMPLITUDE   = AMPLITUDE_DEF,
   parameter int          RD_LAT      = 2
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic [7:0]  song_base,
   output logic [7:0]  mem_address,
   input  logic [31:0] mem_q,
   input  logic        audio_out_allowed,
   output logic        write_audio_out,
   output logic [31:0] left_channel_audio_out,
   output logic [31:0] right_channel_audio_out,
   output logic        busy,
   output logic        done
);

   localparam int TW = $clog2(TICK_CYCLES + 1);
   localparam int FW = $clog2(RD_LAT + 1);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
   localparam logic [FW-1:0] FETCH_LAST = FW'(RD_LAT - 1);

   state_t             state;
   logic [7:0]         base;
   logic [FW-1:0]      fetch_cnt;
   logic [TW-1:0]      tick_cnt;
   logic [DUR_W-1:0]   dur_left;
   logic [7:0]         next_addr;
   logic [DUR_W-1:0]   word_dur;
   logic [HP_W-1:0]    word_hp;
   logic               word_end;
   logic               tone_load;
   logic               tone_en;
   logic signed [31:0] tone_sample;

   assign next_addr = mem_address + 8'd1;
   assign word_end  = mem_q[END_BIT];
   assign word_dur  = mem_q[DUR_MSB:DUR_LSB];
   assign word_hp   = mem_q[HP_MSB:HP_LSB];

   assign tone_load = (state == DECODE) && !word_end && (word_dur != '0);
   assign tone_en   = (state == PLAY);

   tone_gen #(
      .AMPLITUDE (AMPLITUDE)
   ) u_tone (
      .clk         (CLOCK_50),
      .reset       (reset),
      .load        (tone_load),
      .enable      (tone_en),
      .half_period (word_hp),
      .sample      (tone_sample)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state                   <= IDLE;
         base                    <= '0;
         fetch_cnt               <= '0;
         tick_cnt                <= '0;
         dur_left                <= '0;
         mem_address             <= '0;
         write_audio_out         <= 1'b0;
         left_channel_audio_out  <= '0;
         right_channel_audio_out <= '0;
         busy                    <= 1'b0;
         done                    <= 1'b0;
      end else begin
         // strobes and samples fall back to 0 unless PLAY drives them
         write_audio_out         <= 1'b0;
         done                    <= 1'b0;
         left_channel_audio_out  <= '0;
         right_channel_audio_out <= '0;

         if (stop) begin
            // also covers start+stop together in IDLE: stop wins
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     mem_address <= song_base;
                     base        <= song_base;
                     fetch_cnt   <= '0;
                     state       <= FETCH;
                     busy        <= 1'b1;
                  end
               end

               FETCH: begin
                  if (fetch_cnt == FETCH_LAST) begin
                     fetch_cnt <= '0;
                     state     <= DECODE;
                  end else begin
                     fetch_cnt <= fetch_cnt + 1'b1;
                  end
               end

               DECODE: begin
                  if (word_end) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else if (word_dur == '0) begin
                     mem_address <= next_addr;
                     if (next_addr == base) begin
                        state <= FINISH;
                        done  <= 1'b1;
                     end else begin
                        state <= FETCH;
                     end
                  end else begin
                     dur_left <= word_dur;
                     tick_cnt <= '0;
                     state    <= PLAY;
                  end
               end

               PLAY: begin
                  left_channel_audio_out  <= tone_sample;
                  right_channel_audio_out <= tone_sample;
                  // a low cycle always separates two strobes
                  write_audio_out <= audio_out_allowed && !write_audio_out;
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     if (dur_left == DUR_W'(1)) begin
                        mem_address <= next_addr;
                        if (next_addr == base) begin
                           // wrapped all 256 words without an END marker
                           state <= FINISH;
                           done  <= 1'b1;
                        end else begin
                           state <= FETCH;
                        end
                     end else begin
                        dur_left <= dur_left - 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               FINISH: begin
`ifdef SONG_LOOP_EN
                  mem_address <= base;
                  fetch_cnt   <= '0;
                  state       <= FETCH;
`else
                  state <= IDLE;
                  busy  <= 1'b0;
`endif
               end

               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_song_sequencer.sv
`timescale 1ns/1ps
module tb_song_sequencer;

   localparam int          TICK = 10;
   localparam logic [31:0] AMP  = 32'd10000000;
   localparam logic [31:0] NAMP = 32'd0 - 32'd10000000;
   localparam logic [31:0] ENDW = 32'h8000_0000;
`ifdef SONG_LOOP_EN
   localparam int PASSES = 2;
   localparam bit LOOP   = 1'b1;
`else
   localparam int PASSES = 1;
   localparam bit LOOP   = 1'b0;
`endif

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1, start = 1'b0, stop = 1'b0;
   logic [7:0]  song_base = 8'd0;
   logic [7:0]  mem_address;
   logic [31:0] mem_q;
   logic        audio_out_allowed = 1'b0;
   logic        write_audio_out;
   logic [31:0] left_channel_audio_out, right_channel_audio_out;
   logic        busy, done;

   int errors = 0;
   int checks = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   song_sequencer #(.TICK_CYCLES(TICK), .AMPLITUDE(AMP), .RD_LAT(2)) dut (
      .CLOCK_50               (CLOCK_50),
      .reset                  (reset),
      .start                  (start),
      .stop                   (stop),
      .song_base              (song_base),
      .mem_address            (mem_address),
      .mem_q                  (mem_q),
      .audio_out_allowed      (audio_out_allowed),
      .write_audio_out        (write_audio_out),
      .left_channel_audio_out (left_channel_audio_out),
      .right_channel_audio_out(right_channel_audio_out),
      .busy                   (busy),
      .done                   (done)
   );

   // song ROM with two-cycle read latency
   logic [31:0] rom [256];
   logic [31:0] q1;
   always @(posedge CLOCK_50) begin
      q1    <= rom[mem_address];
      mem_q <= q1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   function automatic logic [31:0] note(input int dur, input int hp);
      logic [10:0] d;
      logic [19:0] h;
      d = 11'(dur);
      h = 20'(hp);
      return {1'b0, d, h};
   endfunction

   // Reference timeline: one record per cycle after start, derived from the word rules.
   typedef struct {
      bit          play;
      logic [31:0] smp;
      bit          fin;
   } rec_t;
   rec_t tl[$];

   task automatic push(input bit p, input logic [31:0] s, input bit f);
      rec_t r;
      r.play = p; r.smp = s; r.fin = f;
      tl.push_back(r);
   endtask

   task automatic build(input logic [7:0] b);
      int addr, dur, hp;
      logic [31:0] w;
      tl.delete();
      for (int p = 0; p < PASSES; p++) begin
         addr = int'(b);
         while (1) begin
            push(0, 0, 0); push(0, 0, 0); push(0, 0, 0);   // fetch, fetch, decode
            w = rom[addr];
            if (w[31]) begin push(0, 0, 1); break; end
            dur = int'(w[30:20]);
            hp  = int'(w[19:0]);
            for (int k = 0; k < dur * TICK; k++)
               push(1, (hp == 0) ? 32'd0 : (((k / hp) % 2 == 0) ? AMP : NAMP), 0);
            addr = (addr + 1) % 256;
            if (addr == int'(b)) begin push(0, 0, 1); break; end
         end
      end
   endtask

   // amode: 0 = always allowed, 1 = random, 2 = blocked for cycles [lo,hi)
   task automatic run_model(input logic [7:0] b, input int amode, input int lo, input int hi);
      bit pplay, pal, pwr, ewr, al, ebusy, edone;
      logic [31:0] psmp;
      int n_rec;
      build(b);
      n_rec = tl.size();
      song_base = b;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_addr", {24'd0, mem_address}, {24'd0, b});
      pplay = 0; pal = 0; pwr = 0; psmp = 0;
      for (int n = 0; n <= n_rec; n++) begin
         ewr   = pplay && pal && !pwr;
         ebusy = (n < n_rec) ? 1'b1 : LOOP;
         edone = (n < n_rec) ? tl[n].fin : 1'b0;
         chk("busy", {31'd0, busy}, {31'd0, ebusy});
         chk("done", {31'd0, done}, {31'd0, edone});
         chk("write", {31'd0, write_audio_out}, {31'd0, ewr});
         if (ewr) chk("sample", left_channel_audio_out, psmp);
         chk("right_eq_left", right_channel_audio_out, left_channel_audio_out);
         if (amode == 0)      al = 1'b1;
         else if (amode == 1) al = 1'($urandom_range(0, 1));
         else                 al = !(n >= lo && n < hi);
         audio_out_allowed = al;
         pplay = (n < n_rec) ? tl[n].play : 1'b0;
         psmp  = (n < n_rec) ? tl[n].smp : 32'd0;
         pal   = al;
         pwr   = ewr;
         step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("busy_after_song", {31'd0, busy}, 32'd0);
   endtask

   typedef struct {
      int         setup;
      logic [7:0] base;
      int         cycles;   // cycles from first FETCH through the done pulse
      int         writes;
      int         pos;
      int         neg;
   } vec_t;
   vec_t vt[3];

   initial begin
      int cyc, wr, pos, neg, nw, wait_cnt;
      bit got_done, bad;
      logic [7:0] b;

      for (int i = 0; i < 256; i++) rom[i] = 32'd0;

      // ---- reset state ----
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_write", {31'd0, write_audio_out}, 32'd0);
      chk("rst_left", left_channel_audio_out, 32'd0);
      chk("rst_right", right_channel_audio_out, 32'd0);
      chk("rst_addr", {24'd0, mem_address}, 32'd0);

      // ---- directed table ----
      vt[0] = '{0, 8'd0,   37,   15,   8,   7};
      vt[1] = '{1, 8'd5,   30,   10,   0,   0};
      vt[2] = '{2, 8'd200, 3329, 1280, 768, 512};
      for (int v = 0; v < 3; v++) begin
         case (vt[v].setup)
            0: begin rom[0] = note(3, 4); rom[1] = ENDW; end
            1: begin rom[5] = note(0, 7); rom[6] = note(2, 0); rom[7] = ENDW; end
            default: for (int i = 0; i < 256; i++) rom[i] = note(1, 5);
         endcase
         audio_out_allowed = 1'b1;
         song_base = vt[v].base;
         start = 1'b1;
         step();
         start = 1'b0;
         cyc = 0; wr = 0; pos = 0; neg = 0; got_done = 0;
         for (int n = 0; n < 5000 && !got_done; n++) begin
            cyc++;
            if (write_audio_out) begin
               wr++;
               if (left_channel_audio_out == AMP) pos++;
               else if (left_channel_audio_out == NAMP) neg++;
            end
            if (done) got_done = 1;
            else step();
         end
         chk("tbl_done_seen", {31'd0, got_done}, 32'd1);
         chk("tbl_cycles", cyc, vt[v].cycles);
         chk("tbl_writes", wr, vt[v].writes);
         chk("tbl_pos", pos, vt[v].pos);
         chk("tbl_neg", neg, vt[v].neg);
         step();
         chk("tbl_busy_after", {31'd0, busy}, {31'd0, LOOP});
         if (LOOP) chk("tbl_loop_addr", {24'd0, mem_address}, {24'd0, vt[v].base});
         stop = 1'b1;
         step();
         stop = 1'b0;
         chk("tbl_idle", {31'd0, busy}, 32'd0);
      end

      // ---- output FIFO full for 20 cycles mid-note ----
      rom[10] = note(5, 4); rom[11] = ENDW;
      run_model(8'd10, 2, 10, 30);

      // ---- stop 8 cycles into a note ----
      rom[20] = note(4, 3); rom[21] = ENDW;
      audio_out_allowed = 1'b1;
      song_base = 8'd20;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 11; i++) step();   // 3 fetch/decode cycles + 8 PLAY cycles
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_busy", {31'd0, busy}, 32'd0);
      chk("stop_write", {31'd0, write_audio_out}, 32'd0);
      chk("stop_left", left_channel_audio_out, 32'd0);
      chk("stop_done", {31'd0, done}, 32'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (done || busy) bad = 1;
         step();
      end
      chk("stop_quiet", {31'd0, bad}, 32'd0);
      run_model(8'd20, 0, 0, 0);   // replays from base

      // ---- randomized songs ----
      for (int r = 0; r < 6; r++) begin
         b  = 8'($urandom_range(0, 255));
         nw = $urandom_range(1, 4);
         for (int k = 0; k < nw; k++) begin
            if ($urandom_range(0, 4) == 0)
               rom[(int'(b) + k) % 256] = note(0, $urandom_range(1, 9));
            else
               rom[(int'(b) + k) % 256] = note($urandom_range(1, 3), $urandom_range(0, 8));
         end
         rom[(int'(b) + nw) % 256] = ENDW;
         run_model(b, 1, 0, 0);
      end

      // ---- reset while a write strobe is high ----
      audio_out_allowed = 1'b1;
      song_base = 8'd20;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_cnt = 0;
      while (!write_audio_out && wait_cnt < 100) begin
         step();
         wait_cnt++;
      end
      chk("reset_wait_write", {31'd0, write_audio_out}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_write", {31'd0, write_audio_out}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_left", left_channel_audio_out, 32'd0);
      chk("mid_rst_right", right_channel_audio_out, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_addr", {24'd0, mem_address}, 32'd0);

      // ---- start and stop together from IDLE ----
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (busy || write_audio_out || done) bad = 1;
         step();
      end
      chk("start_stop_idle", {31'd0, bad}, 32'd0);
      chk("start_stop_addr", {24'd0, mem_address}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
